// File: rtl/fir_host_driver.sv
// fir_host_driver: host-side sequencer for the fir_filter core.
// Loads coefficient sets, paces samples against modwait, returns results.
module fir_host_driver #(
    parameter int W          = 16,
    parameter int NUM_COEFF  = 4,
    parameter int COEFF_HOLD = 2,
    parameter int DR_HOLD    = 4,
    parameter int TIMEOUT    = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start_load,
    input  logic [NUM_COEFF*W-1:0] coeff_in,
    input  logic                   in_valid,
    input  logic [W-1:0]           in_data,
    output logic                   in_ready,
    output logic                   load_coeff,
    output logic [W-1:0]           fir_coefficient,
    output logic                   data_ready,
    output logic [W-1:0]           sample_data,
    input  logic                   modwait,
    input  logic [W-1:0]           fir_out,
    input  logic                   err,
    input  logic                   one_k_samples,
    output logic                   out_valid,
    output logic [W-1:0]           out_data,
    output logic                   out_err,
    input  logic                   out_ready,
    output logic                   coeff_loaded,
    output logic                   one_k_seen,
    output logic                   timeout
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam int IW = (NUM_COEFF > 1) ? $clog2(NUM_COEFF) : 1;

    localparam logic [CW-1:0] C_TMO      = CW'(TIMEOUT);
    localparam logic [CW-1:0] C_CH_LAST  = CW'(COEFF_HOLD - 1);
    localparam logic [CW-1:0] C_DR_LAST  = CW'(DR_HOLD - 1);
    localparam logic [IW-1:0] C_IDX_LAST = IW'(NUM_COEFF - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_LOAD_WAIT,
        S_SEND,
        S_WAIT_BUSY,
        S_WAIT_DONE,
        S_RESULT
    } state_t;

    state_t         r_state;
    state_t         w_next;

    logic [W-1:0]   r_coeff [NUM_COEFF];
    logic [IW-1:0]  r_idx;
    logic [CW-1:0]  r_cnt;
    logic [W-1:0]   r_sample;
    logic           r_busy_seen;
    logic [W-1:0]   r_out_data;
    logic           r_out_err;
    logic           r_coeff_loaded;
    logic           r_one_k;
    logic           r_timeout;

    logic           w_in_ready;
    logic           w_load_coeff;
    logic           w_data_ready;
    logic           w_out_valid;
    logic           w_acc_load;
    logic           w_acc_smp;
    logic           w_coeff_step;
    logic           w_set_loaded;
    logic           w_capture;
    logic           w_tmo_hit;
    logic           w_tmo_flag;
    logic           w_tmo_res;
    logic           w_cnt_clr;

    // State register; reset aborts any operation in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode plus the strobes that steer the datapath.
    always_comb begin
        w_next       = r_state;
        w_in_ready   = 1'b0;
        w_load_coeff = 1'b0;
        w_data_ready = 1'b0;
        w_out_valid  = 1'b0;
        w_acc_load   = 1'b0;
        w_acc_smp    = 1'b0;
        w_coeff_step = 1'b0;
        w_set_loaded = 1'b0;
        w_capture    = 1'b0;
        w_tmo_flag   = 1'b0;
        w_tmo_res    = 1'b0;
        w_tmo_hit    = (r_cnt == C_TMO);
        unique case (r_state)
            S_IDLE: begin
                w_in_ready = r_coeff_loaded && !rst;
                if (start_load) begin
                    w_acc_load = 1'b1;
                    w_next     = S_LOAD;
                end else if (in_valid && w_in_ready) begin
                    w_acc_smp = 1'b1;
                    w_next    = S_SEND;
                end
            end
            S_LOAD: begin
                w_load_coeff = 1'b1;
                if (r_cnt == C_CH_LAST) begin
                    if (r_idx == C_IDX_LAST) begin
                        w_next = S_LOAD_WAIT;
                    end else begin
                        w_coeff_step = 1'b1;
                    end
                end
            end
            S_LOAD_WAIT: begin
                if (!modwait) begin
                    w_set_loaded = 1'b1;
                    w_next       = S_IDLE;
                end else if (w_tmo_hit) begin
                    w_tmo_flag = 1'b1;
                    w_next     = S_IDLE;
                end
            end
            S_SEND: begin
                w_data_ready = 1'b1;
                if (r_cnt == C_DR_LAST) begin
                    w_next = S_WAIT_BUSY;
                end
            end
            S_WAIT_BUSY: begin
                if (modwait || r_busy_seen) begin
                    w_next = S_WAIT_DONE;
                end else if (w_tmo_hit) begin
                    w_tmo_flag = 1'b1;
                    w_tmo_res  = 1'b1;
                    w_next     = S_RESULT;
                end
            end
            S_WAIT_DONE: begin
                if (!modwait) begin
                    w_capture = 1'b1;
                    w_next    = S_RESULT;
                end else if (w_tmo_hit) begin
                    w_tmo_flag = 1'b1;
                    w_tmo_res  = 1'b1;
                    w_next     = S_RESULT;
                end
            end
            S_RESULT: begin
                w_out_valid = 1'b1;
                if (out_ready) begin
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
        w_cnt_clr = (w_next != r_state) || w_coeff_step;
    end

    // Shared cycle counter: restarts per state and per coefficient, saturates.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (w_cnt_clr) begin
            r_cnt <= '0;
        end else if (r_cnt != C_TMO) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Coefficient shadow, index and the loaded flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_COEFF; i++) begin
                r_coeff[i] <= '0;
            end
            r_idx          <= '0;
            r_coeff_loaded <= 1'b0;
        end else if (w_acc_load) begin
            for (int i = 0; i < NUM_COEFF; i++) begin
                r_coeff[i] <= coeff_in[i*W +: W];
            end
            r_idx          <= '0;
            r_coeff_loaded <= 1'b0;
        end else begin
            if (w_coeff_step) begin
                r_idx <= r_idx + 1'b1;
            end
            if (w_set_loaded) begin
                r_coeff_loaded <= 1'b1;
            end
        end
    end

    // Sample latch and early-busy tracking while data_ready is up.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sample    <= '0;
            r_busy_seen <= 1'b0;
        end else if (w_acc_smp) begin
            r_sample    <= in_data;
            r_busy_seen <= 1'b0;
        end else if (r_state == S_SEND && modwait) begin
            r_busy_seen <= 1'b1;
        end
    end

    // Result capture; a timeout yields a zero result flagged as error.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_data <= '0;
            r_out_err  <= 1'b0;
        end else if (w_capture) begin
            r_out_data <= fir_out;
            r_out_err  <= err;
        end else if (w_tmo_res) begin
            r_out_data <= '0;
            r_out_err  <= 1'b1;
        end
    end

    // Sticky status flags, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_one_k   <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            if (one_k_samples) begin
                r_one_k <= 1'b1;
            end
            if (w_tmo_flag) begin
                r_timeout <= 1'b1;
            end
        end
    end

    assign in_ready        = w_in_ready;
    assign load_coeff      = w_load_coeff;
    assign fir_coefficient = w_load_coeff ? r_coeff[r_idx] : '0;
    assign data_ready      = w_data_ready;
    assign sample_data     = r_sample;
    assign out_valid       = w_out_valid;
    assign out_data        = r_out_data;
    assign out_err         = r_out_err;
    assign coeff_loaded    = r_coeff_loaded;
    assign one_k_seen      = r_one_k;
    assign timeout         = r_timeout;

endmodule
